// File: rtl/hb_boot_pkg.sv
// Shared types and constants for the power-on image loader.
// Imported by the loader FSM and its EEPROM wait timer.
package hb_boot_pkg;

    localparam logic [11:0] IO_BASE_DEF = 12'hFF0;
    localparam int          WAIT_W      = 3;

    typedef enum logic [2:0] {
        CP_RD,
        CP_WR,
        CP_REC,
        VF_RD,
        VF_CMP,
        DONE,
        ERROR
    } boot_state_e;

endpackage

// File: rtl/boot_wait_timer.sv
// EEPROM access-time down-counter for the loader read states.
// The load cycle is the first cycle of a read, so a read lasts EE_WAIT+1.
module boot_wait_timer
    import hb_boot_pkg::*;
#(
    parameter int EE_WAIT = 2
) (
    input  logic clk,
    input  logic rst_bar,
    input  logic load,
    input  logic en,
    output logic expired
);

    localparam logic [WAIT_W-1:0] WAIT_V = WAIT_W'(EE_WAIT);
    localparam logic [WAIT_W-1:0] ONE    = WAIT_W'(1);

    logic [WAIT_W-1:0] cnt;
    logic [WAIT_W-1:0] cnt_ld;

    assign cnt_ld  = (WAIT_V == '0) ? '0 : WAIT_V - ONE;
    assign expired = load ? (WAIT_V == '0) : (cnt == '0);

    always_ff @(posedge clk or negedge rst_bar) begin
        if (!rst_bar) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= cnt_ld;
        end else if (en && cnt != '0) begin
            cnt <= cnt - ONE;
        end
    end

endmodule

// File: rtl/boot_loader_ctrl.sv
// Copies the EEPROM image into RAM at power-on, optionally verifies it,
// then releases the buses and the core reset.
module boot_loader_ctrl
    import hb_boot_pkg::*;
#(
    parameter int                ADDR_W   = 12,
    parameter int                DATA_W   = 8,
    parameter logic [ADDR_W-1:0] LOAD_LEN = 'hFF0,
    parameter logic [ADDR_W-1:0] IO_BASE  = ADDR_W'(IO_BASE_DEF),
    parameter int                EE_WAIT  = 2,
    parameter bit                VERIFY   = 1'b1
) (
    input  logic              clk,
    input  logic              rst_bar,
    output logic [ADDR_W-1:0] ee_addr,
    output logic              ee_ce_bar,
    output logic              ee_oe_bar,
    input  logic [DATA_W-1:0] ee_data,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_ce_bar,
    output logic              ram_we_bar,
    output logic              ram_oe_bar,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              cpu_rst_bar,
    output logic              bootloader_done,
    output logic              boot_error,
    output logic [ADDR_W-1:0] err_addr
);

    localparam logic [ADDR_W-1:0] LEN =
        (LOAD_LEN < IO_BASE) ? LOAD_LEN : IO_BASE;
    localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] LAST = LEN - ONE;

    boot_state_e       state, state_d;
    logic [ADDR_W-1:0] addr, addr_d;
    logic [DATA_W-1:0] hold, hold_d;
    logic              rd_first, rd_first_d;
    logic              in_rd, rd_d, expired, last;

    logic [ADDR_W-1:0] ee_addr_d, ram_addr_d, err_addr_d;
    logic [DATA_W-1:0] ram_wdata_d;
    logic              ee_ce_d, ee_oe_d;
    logic              ram_ce_d, ram_we_d, ram_oe_d;
    logic              cpu_rst_d, done_d, err_d;

    assign in_rd = (state == CP_RD) || (state == VF_RD);
    assign last  = (addr == LAST);

    boot_wait_timer #(
        .EE_WAIT(EE_WAIT)
    ) u_timer (
        .clk     (clk),
        .rst_bar (rst_bar),
        .load    (rd_first),
        .en      (in_rd),
        .expired (expired)
    );

    always_comb begin
        state_d    = state;
        addr_d     = addr;
        hold_d     = hold;
        err_addr_d = err_addr;
        unique case (state)
            CP_RD: begin
                if (LEN == '0) begin
                    state_d = DONE;
                end else if (expired) begin
                    hold_d  = ee_data;
                    state_d = CP_WR;
                end
            end
            CP_WR: state_d = CP_REC;
            CP_REC: begin
                if (last) begin
                    addr_d  = '0;
                    state_d = VERIFY ? VF_RD : DONE;
                end else begin
                    addr_d  = addr + ONE;
                    state_d = CP_RD;
                end
            end
            VF_RD: begin
                if (expired) begin
                    hold_d  = ee_data;
                    state_d = VF_CMP;
                end
            end
            VF_CMP: begin
                if (hold != ram_rdata) begin
                    err_addr_d = addr;
                    state_d    = ERROR;
                end else if (last) begin
                    state_d = DONE;
                end else begin
                    addr_d  = addr + ONE;
                    state_d = VF_RD;
                end
            end
            DONE, ERROR: state_d = state;
            default:     state_d = state;
        endcase
        rd_d       = (state_d == CP_RD) || (state_d == VF_RD);
        rd_first_d = rd_d && (state_d != state);
    end

    // Outputs are decoded from the next state so every pin is a flop;
    // ram_addr is set up during the read so the strobe never moves it.
    always_comb begin
        ee_ce_d     = 1'b1;
        ee_oe_d     = 1'b1;
        ee_addr_d   = '0;
        ram_ce_d    = 1'b1;
        ram_we_d    = 1'b1;
        ram_oe_d    = 1'b1;
        ram_addr_d  = ram_addr;
        ram_wdata_d = ram_wdata;
        cpu_rst_d   = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;
        unique case (state_d)
            CP_RD: begin
                ee_ce_d    = 1'b0;
                ee_oe_d    = 1'b0;
                ee_addr_d  = addr_d;
                ram_addr_d = addr_d;
            end
            CP_WR: begin
                ram_ce_d    = 1'b0;
                ram_we_d    = 1'b0;
                ram_addr_d  = addr_d;
                ram_wdata_d = hold_d;
            end
            CP_REC: ram_ce_d = 1'b0;
            VF_RD, VF_CMP: begin
                ee_ce_d    = (state_d != VF_RD);
                ee_oe_d    = (state_d != VF_RD);
                ee_addr_d  = (state_d == VF_RD) ? addr_d : '0;
                ram_ce_d   = 1'b0;
                ram_oe_d   = 1'b0;
                ram_addr_d = addr_d;
            end
            DONE: begin
                ram_addr_d = '0;
                cpu_rst_d  = 1'b1;
                done_d     = 1'b1;
            end
            ERROR: begin
                ram_addr_d = '0;
                err_d      = 1'b1;
            end
            default: ram_addr_d = ram_addr;
        endcase
    end

    always_ff @(posedge clk or negedge rst_bar) begin
        if (!rst_bar) begin
            state           <= CP_RD;
            addr            <= '0;
            hold            <= '0;
            rd_first        <= 1'b1;
            ee_addr         <= '0;
            ee_ce_bar       <= 1'b1;
            ee_oe_bar       <= 1'b1;
            ram_addr        <= '0;
            ram_ce_bar      <= 1'b1;
            ram_we_bar      <= 1'b1;
            ram_oe_bar      <= 1'b1;
            ram_wdata       <= '0;
            cpu_rst_bar     <= 1'b0;
            bootloader_done <= 1'b0;
            boot_error      <= 1'b0;
            err_addr        <= '0;
        end else begin
            state           <= state_d;
            addr            <= addr_d;
            hold            <= hold_d;
            rd_first        <= rd_first_d;
            ee_addr         <= ee_addr_d;
            ee_ce_bar       <= ee_ce_d;
            ee_oe_bar       <= ee_oe_d;
            ram_addr        <= ram_addr_d;
            ram_ce_bar      <= ram_ce_d;
            ram_we_bar      <= ram_we_d;
            ram_oe_bar      <= ram_oe_d;
            ram_wdata       <= ram_wdata_d;
            cpu_rst_bar     <= cpu_rst_d;
            bootloader_done <= done_d;
            boot_error      <= err_d;
            err_addr        <= err_addr_d;
        end
    end

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// Bench for boot_loader_ctrl: four loader configurations side by side
// against EEPROM/RAM models and an arithmetic timing/content model.
module tb_boot_loader_ctrl;

    localparam int N = 4;
    localparam int W = 2;

    logic clk;
    logic rst_bar;
    logic [N-1:0] bad;

    logic [11:0] ee_addr   [N];
    logic [11:0] ram_addr  [N];
    logic [11:0] err_addr  [N];
    logic [7:0]  ee_data   [N];
    logic [7:0]  ram_wdata [N];
    logic [7:0]  ram_rdata [N];
    logic ee_ce_bar  [N];
    logic ee_oe_bar  [N];
    logic ram_ce_bar [N];
    logic ram_we_bar [N];
    logic ram_oe_bar [N];
    logic cpu_rst_bar[N];
    logic done       [N];
    logic berr       [N];

    logic [7:0] ee_mem [N][4096];
    logic [7:0] ram    [N][4096];

    int cyc;
    int nwr [N];
    int nfall [N];
    int viol [N];
    int maxwa [N];
    int done_at [N];
    logic prev_we [N];
    logic [11:0] prev_ra [N];

    int n_assert = 0;
    int n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 0: len 4 copy only, 1: len 4 with verify,
    // 2: len FFF (clipped at IO), 3: len 0
    for (genvar i = 0; i < N; i++) begin : g_dut
        boot_loader_ctrl #(
            .EE_WAIT (W),
            .VERIFY  (i == 1),
            .LOAD_LEN((i < 2) ? 12'h004 :
                      (i == 2) ? 12'hFFF : 12'h000)
        ) u_dut (
            .clk            (clk),
            .rst_bar        (rst_bar),
            .ee_addr        (ee_addr[i]),
            .ee_ce_bar      (ee_ce_bar[i]),
            .ee_oe_bar      (ee_oe_bar[i]),
            .ee_data        (ee_data[i]),
            .ram_addr       (ram_addr[i]),
            .ram_ce_bar     (ram_ce_bar[i]),
            .ram_we_bar     (ram_we_bar[i]),
            .ram_oe_bar     (ram_oe_bar[i]),
            .ram_wdata      (ram_wdata[i]),
            .ram_rdata      (ram_rdata[i]),
            .cpu_rst_bar    (cpu_rst_bar[i]),
            .bootloader_done(done[i]),
            .boot_error     (berr[i]),
            .err_addr       (err_addr[i])
        );
        assign ee_data[i] = ee_mem[i][ee_addr[i]];
        assign ram_rdata[i] =
            (bad[i] && ram_addr[i] == 12'h002) ? 8'h00
                                               : ram[i][ram_addr[i]];
    end

    function automatic logic [7:0] junk(input int a);
        return 8'hA5 ^ 8'(a) ^ 8'(a >> 8);
    endfunction

    function automatic int exp_len(input int load_len);
        return (load_len < 'hFF0) ? load_len : 'hFF0;
    endfunction

    function automatic int exp_done(input int len, input bit vf);
        if (len == 0) return 1;
        return len * (W + 3) + (vf ? len * (W + 2) : 0);
    endfunction

    always @(posedge clk) begin
        if (!rst_bar) begin
            for (int i = 0; i < N; i++)
                for (int a = 0; a < 4096; a++)
                    ram[i][a] <= junk(a);
        end else begin
            for (int i = 0; i < N; i++)
                if (!ram_ce_bar[i] && !ram_we_bar[i])
                    ram[i][ram_addr[i]] <= ram_wdata[i];
        end
    end

    always @(posedge clk or negedge rst_bar) begin
        if (!rst_bar) begin
            cyc <= 0;
            for (int i = 0; i < N; i++) begin
                nwr[i]     <= 0;
                nfall[i]   <= 0;
                viol[i]    <= 0;
                maxwa[i]   <= -1;
                prev_we[i] <= 1'b1;
                prev_ra[i] <= '0;
            end
        end else begin
            cyc <= cyc + 1;
            for (int i = 0; i < N; i++) begin
                if (!ram_ce_bar[i] && !ram_we_bar[i]) begin
                    nwr[i] <= nwr[i] + 1;
                    if (int'(ram_addr[i]) > maxwa[i])
                        maxwa[i] <= int'(ram_addr[i]);
                end
                if (!ram_we_bar[i] && prev_we[i])
                    nfall[i] <= nfall[i] + 1;
                viol[i] <= viol[i]
                    + int'(!ram_we_bar[i] && prev_we[i]
                           && ram_addr[i] != prev_ra[i])
                    + int'(!ram_we_bar[i] && !ram_oe_bar[i]);
                prev_we[i] <= ram_we_bar[i];
                prev_ra[i] <= ram_addr[i];
            end
        end
    end

    always @(negedge clk or negedge rst_bar) begin
        if (!rst_bar) begin
            for (int i = 0; i < N; i++) done_at[i] <= 0;
        end else begin
            for (int i = 0; i < N; i++)
                if (done[i] && done_at[i] == 0) done_at[i] <= cyc;
        end
    end

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h",
                   tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_bar = 1'b0;
        @(negedge clk);
        rst_bar = 1'b1;
    endtask

    task automatic wait_end(input int i, input int bound,
                            input string tag);
        int k = 0;
        while (!(done[i] || berr[i]) && k < bound) begin
            @(negedge clk);
            k++;
        end
        check(tag, 32'(done[i] || berr[i]), 32'd1);
        @(negedge clk);
    endtask

    function automatic int img_err(input int i, input int len);
        int m = 0;
        for (int a = 0; a < len; a++)
            if (ram[i][a] !== ee_mem[i][a]) m++;
        return m;
    endfunction

    function automatic logic [7:0] pins(input int i);
        return {ee_ce_bar[i], ee_oe_bar[i], ram_ce_bar[i],
                ram_we_bar[i], ram_oe_bar[i], cpu_rst_bar[i],
                done[i], berr[i]};
    endfunction

    initial begin
        logic [7:0] img [4];
        int k;
        img = '{8'h3A, 8'h00, 8'hFF, 8'h5C};
        rst_bar = 1'b0;
        bad = '0;
        for (int i = 0; i < N; i++)
            for (int a = 0; a < 4096; a++)
                ee_mem[i][a] = (a < 4) ? img[a] : 8'($urandom);
        @(negedge clk);
        @(negedge clk);

        check("rst_pins", 32'(pins(0)), 32'hF8);
        check("rst_addr", {ee_addr[1], ram_addr[1]}, 32'h0);
        check("rst_err", {ram_wdata[1], err_addr[1]}, 32'h0);

        // directed image, copy-only / verify / zero length
        rst_bar = 1'b1;
        wait_end(1, 100, "b_end");
        check("a_done_cyc", done_at[0], exp_done(4, 1'b0));
        check("a_image", img_err(0, 4), 0);
        check("a_strobes", nwr[0], 4);
        check("a_strobe_w", nfall[0], 4);
        check("a_viol", viol[0], 0);
        check("a_pins", 32'(pins(0)), 32'hFE);
        check("a_bus", {ee_addr[0], ram_addr[0]}, 32'h0);
        check("b_done_cyc", done_at[1], exp_done(4, 1'b1));
        check("b_image", img_err(1, 4), 0);
        check("b_err", 32'(berr[1]), 32'd0);
        check("b_viol", viol[1], 0);
        check("d_done_cyc", done_at[3], exp_done(0, 1'b0));
        check("d_strobes", nwr[3], 0);

        // verify pass sees a corrupted byte 2
        bad[1] = 1'b1;
        do_reset();
        wait_end(1, 100, "berr_end");
        check("berr_flag", 32'(berr[1]), 32'd1);
        check("berr_addr", err_addr[1], 32'h002);
        repeat (5) @(negedge clk);
        check("berr_pins", 32'(pins(1)), 32'hF9);
        bad[1] = 1'b0;

        // one-cycle reset in the middle of byte 2
        do_reset();
        k = 0;
        while (cyc < 12 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("mid_ee_addr", ee_addr[0], 32'h002);
        check("mid_ee_ce", 32'(ee_ce_bar[0]), 32'd0);
        rst_bar = 1'b0;
        #1;
        check("mid_async", 32'(pins(0)), 32'hF8);
        check("mid_addr", ee_addr[0], 32'h0);
        @(negedge clk);
        rst_bar = 1'b1;
        wait_end(0, 100, "mid_end");
        check("mid_done_cyc", done_at[0], exp_done(4, 1'b0));
        check("mid_strobes", nwr[0], 4);
        check("mid_image", img_err(0, 4), 0);

        // random images, including the full-length clipped copy
        for (int i = 0; i < 3; i++)
            for (int a = 0; a < 4096; a++)
                ee_mem[i][a] = 8'($urandom);
        do_reset();
        wait_end(2, 21000, "c_end");
        check("c_done_cyc", done_at[2], exp_done(exp_len('hFFF), 0));
        check("c_strobes", nwr[2], exp_len('hFFF));
        check("c_strobe_w", nfall[2], exp_len('hFFF));
        check("c_last_wr", maxwa[2], exp_len('hFFF) - 1);
        check("c_image", img_err(2, exp_len('hFFF)), 0);
        k = 0;
        for (int a = 'hFF0; a < 4096; a++)
            if (ram[2][a] !== junk(a)) k++;
        check("c_io_clean", k, 0);
        check("c_viol", viol[2], 0);
        check("r_a_image", img_err(0, 4), 0);
        check("r_b_image", img_err(1, 4), 0);
        check("r_b_done", 32'(pins(1)), 32'hFE);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/boot_loader_ctrl.md
Name: boot_loader_ctrl

Overview:
- Sequences the power-on copy of the program image from the 8Kx8 EEPROM into the 32Kx8 RAM, then optionally read-back verifies it.
- Holds the CPU core in reset (`cpu_rst_bar` low) throughout; raises `bootloader_done` and releases both memory buses when finished.
- Sits between board reset logic, EEPROM, RAM and the phase/PC logic of the core.
- Never writes the IO window (0xFF0-0xFFF).

Parameters:
- ADDR_W, 12, byte address width seen by the core.
- DATA_W, 8, data width.
- LOAD_LEN, 12'hFF0, number of bytes copied from address 0; effective length is min(LOAD_LEN, IO_BASE).
- IO_BASE, 12'hFF0, first IO-mapped address; copy and verify stop below it.
- EE_WAIT, 2, extra cycles the EEPROM address is held before data is sampled (0..7).
- VERIFY, 1, 1 = run the read-back compare pass after the copy.

Ports:
- clk, in, 1, system clock; all state changes on the rising edge.
- rst_bar, in, 1, asynchronous active-low reset.
- ee_addr, out, ADDR_W, EEPROM byte address.
- ee_ce_bar, out, 1, EEPROM chip enable (active low).
- ee_oe_bar, out, 1, EEPROM output enable (active low).
- ee_data, in, DATA_W, EEPROM read data.
- ram_addr, out, ADDR_W, RAM byte address.
- ram_ce_bar, out, 1, RAM chip enable (active low).
- ram_we_bar, out, 1, RAM write strobe (active low).
- ram_oe_bar, out, 1, RAM output enable (active low).
- ram_wdata, out, DATA_W, RAM write data; tri-state is handled outside this block.
- ram_rdata, in, DATA_W, RAM read data (verify pass).
- cpu_rst_bar, out, 1, core reset (active low); low until DONE.
- bootloader_done, out, 1, high once the image is loaded and verified.
- boot_error, out, 1, high on verify mismatch; sticky until rst_bar.
- err_addr, out, ADDR_W, address of the first mismatch.

Behaviour:
- Reset (asynchronous, active-low rst_bar):
  - state = CP_RD, addr = 0, wait counter = 0.
  - ee_ce_bar = ee_oe_bar = 1; ram_ce_bar = ram_we_bar = ram_oe_bar = 1.
  - ee_addr = ram_addr = 0, ram_wdata = 0.
  - cpu_rst_bar = 0, bootloader_done = 0, boot_error = 0, err_addr = 0.
- LEN = min(LOAD_LEN, IO_BASE). If LEN = 0, the first edge after reset release goes straight to DONE.
- States:
  - CP_RD:
    - ee_ce_bar = ee_oe_bar = 0, ee_addr = addr.
    - Stays EE_WAIT+1 cycles; on the final edge latches ee_data into a holding register, then goes to CP_WR.
  - CP_WR (1 cycle):
    - ram_ce_bar = 0, ram_we_bar = 0, ram_addr = addr, ram_wdata = holding register.
    - EEPROM enables deasserted.
  - CP_REC (1 cycle):
    - ram_we_bar = 1; ram_ce_bar, ram_addr and ram_wdata held (data hold time).
    - If addr = LEN-1: addr := 0, next state = VF_RD if VERIFY else DONE.
    - Otherwise addr += 1, back to CP_RD.
  - Copy cost is EE_WAIT+3 cycles per byte; 5 at default.
  - VF_RD:
    - Same EEPROM timing as CP_RD.
    - ram_ce_bar = ram_oe_bar = 0, ram_addr = addr.
  - VF_CMP (1 cycle), compares the holding register against ram_rdata:
    - Mismatch: go to ERROR, err_addr := addr.
    - Match at LEN-1: go to DONE.
    - Otherwise addr += 1, back to VF_RD.
  - Verify cost is EE_WAIT+2 cycles per byte.
  - DONE (terminal):
    - All chip selects high and ee_addr/ram_addr = 0 (bus released to core).
    - cpu_rst_bar = 1 and bootloader_done = 1, both registered and asserted in the same cycle.
  - ERROR (terminal): buses released, boot_error = 1, cpu_rst_bar stays 0, bootloader_done = 0.
- Invariants:
  - ram_we_bar never falls in the same cycle as a ram_addr change, and never while ram_oe_bar = 0.
  - No write ever targets an address >= IO_BASE.
- Address arithmetic is ADDR_W-bit unsigned. The LEN-1 compare precedes any increment, so no wrap is possible.
- rst_bar low mid-copy or mid-verify aborts immediately to reset values. The next deassertion restarts at address 0; partial RAM content is simply overwritten.
- All outputs are registered: no combinational path from inputs to outputs.

Decomposition:
- Package hb_boot_pkg holds:
  - the state enum (CP_RD, CP_WR, CP_REC, VF_RD, VF_CMP, DONE, ERROR);
  - the IO_BASE default;
  - the EE_WAIT counter width (3 bits).
- One sub-module, boot_wait_timer: a 3-bit down-counter loaded with EE_WAIT on entry to a read state, asserting `expired` when it reaches 0.
- FSM, address counter and compare logic stay in the top module.

Test Plan:
- EE_WAIT=2, VERIFY=0, LOAD_LEN=4, EEPROM = {0x3A, 0x00, 0xFF, 0x5C}:
  - RAM[0..3] match the image;
  - exactly 4 write strobes, each one cycle wide;
  - bootloader_done rises 20 cycles after rst_bar release.
- Same image with VERIFY=1 -> bootloader_done rises at cycle 36 (20 + 4×4); boot_error stays 0.
- VERIFY=1 with a RAM model that forces RAM[2] = 0x00 -> ERROR, boot_error = 1, err_addr = 0x002, cpu_rst_bar stays 0.
- LOAD_LEN=12'hFFF -> no write to 0xFF0..0xFFF; last write at address 0xFEF.
- LOAD_LEN=0 -> bootloader_done = 1 one cycle after reset release, with zero RAM strobes.
- Assert rst_bar low during byte 2 of the copy for 1 cycle:
  - all enables go high asynchronously;
  - after release, the copy restarts at address 0 and completes correctly.
